multicycle_main_control: RTL
============================

Name: multicycle_main_control

Overview:
- Moore-style main control FSM for the multi-cycle RISC-V datapath.
- Decodes the latched instruction opcode and sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the 2-bit ALUOp consumed by the ALU control decoder: 00 add, 01 subtract/compare, 10 use funct fields.
- Also drives datapath strobes and muxes, and handles a ready handshake to memory with a bounded wait.

Parameters:
- MEM_WAIT_MAX, 15: maximum cycles spent waiting on mem_ready in a memory state before bus_err is raised (legal range 1..255).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; forces the FSM to FETCH.
- opcode  in  7  instruction[6:0] from the instruction register; stable outside FETCH.
- mem_ready  in  1  memory completes the current access in this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load qualified by the ALU zero flag (beq).
- PCSource  out  1  0 = ALU result, 1 = ALUOut register.
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction register load.
- OldPCWrite  out  1  capture the pre-increment PC.
- MemtoReg  out  1  register writeback source: 0 = ALUOut, 1 = MDR.
- RegWrite  out  1  register file write.
- ALUSrcA  out  2  00 = PC, 01 = register A, 10 = OldPC.
- ALUSrcB  out  2  00 = register B, 01 = constant 4, 10 = immediate.
- ALUOp  out  2  to the ALU control decoder.
- instr_done  out  1  one-cycle pulse in the final state of each instruction.
- illegal  out  1  one-cycle pulse for an unsupported opcode.
- bus_err  out  1  one-cycle pulse on memory wait timeout.
- state  out  4  current state, for debug.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8. Codes 9-15 return to FETCH on the next edge and assert no outputs.
- Defaults: every output is 0 unless listed for the current state.
- Reset while high: state=FETCH, wait counter=0. All strobes (PCWrite, PCWriteCond, IRWrite, OldPCWrite, MemRead, MemWrite, RegWrite) and all pulses are forced to 0, overriding FETCH decode.
- Reset mid-instruction aborts the instruction; no strobe fires in the reset cycle.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=00, PCSource=0.
  - When mem_ready=1: IRWrite=1, PCWrite=1, OldPCWrite=1, next state DECODE.
  - Otherwise stay in FETCH and count.
- DECODE:
  - Outputs: ALUSrcA=10, ALUSrcB=10, ALUOp=00 (branch target into ALUOut).
  - Next by opcode: 0000011 (lw) and 0100011 (sw) -> MEMADR; 0110011 (R-type) -> EXEC; 1100011 (beq) -> BRANCH.
  - Any other opcode: illegal=1, instr_done=1, next FETCH.
- MEMADR: ALUSrcA=01, ALUSrcB=10, ALUOp=00. Next MEMRD if opcode=lw, else MEMWR.
- MEMRD: MemRead=1, IorD=1. When mem_ready=1, next MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, instr_done=1. Next FETCH.
- MEMWR: MemWrite=1, IorD=1. When mem_ready=1, instr_done=1, next FETCH.
- EXEC: ALUSrcA=01, ALUSrcB=00, ALUOp=10. Next ALUWB.
- ALUWB: RegWrite=1, MemtoReg=0, instr_done=1. Next FETCH.
- BRANCH: ALUSrcA=01, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=1, instr_done=1. Next FETCH.
- Wait counter (8 bits):
  - Cleared on entry to FETCH, MEMRD and MEMWR, and whenever mem_ready=1.
  - Increments each cycle spent in one of those states with mem_ready=0.
  - When the counter equals MEM_WAIT_MAX-1 and mem_ready=0: bus_err=1 for one cycle and next state FETCH. In FETCH this is a retry: the counter clears and the PC is not written.
  - mem_ready=1 in the same cycle as the timeout: completion wins and bus_err stays 0.
- Strobes are combinational from state, plus mem_ready in FETCH, MEMRD and MEMWR. The state register is the only storage besides the wait counter.
- Latency with zero wait (mem_ready high on the first cycle of each access):
  - lw: 5 cycles.
  - sw: 4 cycles.
  - R-type: 4 cycles.
  - beq: 3 cycles.
  - Illegal opcode: 2 cycles.
- opcode is sampled only in DECODE and MEMADR.

Test Plan:
- Reset asserted mid-MEMWR with mem_ready=1 -> MemWrite=0 immediately, state=0; after release FETCH drives MemRead=1 and IRWrite=0 until mem_ready.
- R-type 0110011 with mem_ready tied high -> states 0,1,6,7,0; ALUOp=10 only in EXEC; RegWrite=1 only in ALUWB; instr_done at cycle 4.
- lw 0000011 with 2 stall cycles in MEMRD -> states 0,1,2,3,3,3,4; MemtoReg=1 and RegWrite=1 in MEMWB; no bus_err.
- beq 1100011 -> BRANCH with ALUOp=01, PCWriteCond=1, PCSource=1; PCWrite=0 outside FETCH.
- Opcode 1111111 -> illegal and instr_done pulse in DECODE, next FETCH, RegWrite/MemWrite never 1.
- MEM_WAIT_MAX=3, sw with mem_ready held low -> bus_err one cycle on the 3rd MEMWR cycle, return to FETCH; repeat with mem_ready=1 on that cycle -> no bus_err, instr_done=1.

Source files
------------

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multi-cycle RISC-V datapath: sequences fetch/decode/
// execute/memory/writeback, drives ALUOp and datapath strobes, bounds memory waits.
module multicycle_main_control #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       PCSource,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       OldPCWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       instr_done,
  output logic       illegal,
  output logic       bus_err,
  output logic [3:0] state
);

  // state  | meaning
  // FETCH  | read instruction at PC, PC += 4 on completion
  // DECODE | branch target into ALUOut, dispatch on opcode
  // MEMADR | effective address for lw/sw
  // MEMRD  | data read at ALUOut
  // MEMWB  | MDR into register file
  // MEMWR  | data write at ALUOut
  // EXEC   | R-type ALU operation
  // ALUWB  | ALUOut into register file
  // BRANCH | compare, conditional PC load from ALUOut
  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

  logic [3:0] state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       wait_st;
  logic       timeout;

  assign wait_st = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  // Completion in the timeout cycle takes priority over the error.
  assign timeout = wait_st && !mem_ready && (wait_q == WAIT_LAST);
  assign state   = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Counter is zero outside the wait states, so entering one starts from zero.
  always_comb begin
    wait_d = '0;
    if (wait_st && !mem_ready && !timeout) wait_d = wait_q + 8'd1;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: begin
        if (mem_ready)    state_d = S_DECODE;
        else              state_d = S_FETCH;
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (mem_ready)    state_d = S_MEMWB;
        else if (timeout) state_d = S_FETCH;
        else              state_d = S_MEMRD;
      end
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR: begin
        if (mem_ready || timeout) state_d = S_FETCH;
        else                      state_d = S_MEMWR;
      end
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    OldPCWrite  = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    instr_done  = 1'b0;
    illegal     = 1'b0;
    bus_err     = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead    = 1'b1;
        ALUSrcB    = 2'b01;
        IRWrite    = mem_ready;
        PCWrite    = mem_ready;
        OldPCWrite = mem_ready;
        bus_err    = timeout;
      end
      S_DECODE: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b10;
        if (opcode != OP_LW && opcode != OP_SW && opcode != OP_R && opcode != OP_BEQ) begin
          illegal    = 1'b1;
          instr_done = 1'b1;
        end
      end
      S_MEMADR: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        bus_err = timeout;
      end
      S_MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
        bus_err    = timeout;
      end
      S_EXEC: begin
        ALUSrcA = 2'b01;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 2'b01;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 1'b1;
        instr_done  = 1'b1;
      end
      default: ;
    endcase
    // Reset overrides FETCH decode so nothing fires in the aborting cycle.
    if (reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IRWrite     = 1'b0;
      OldPCWrite  = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      RegWrite    = 1'b0;
      instr_done  = 1'b0;
      illegal     = 1'b0;
      bus_err     = 1'b0;
    end
  end

endmodule
